// File: rtl/mem_dbus_stage.sv
// mem_dbus_stage: MEM stage that runs load/store micro-ops as single-beat req/ack data-bus accesses, stalling the pipe until done.
// Define UNALIGNED_EXC_EN to trap misaligned accesses (excp_adel/excp_ades); otherwise low address bits are forced to alignment.
module mem_dbus_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            mem_op,
  input  logic [DATA_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_store_data,
  input  logic [DATA_W-1:0]     ex_reg_write_data,
  input  logic [REG_ADDR_W-1:0] ex_reg_write_addr,
  input  logic                  ex_reg_write_en,
  input  logic [DATA_W-1:0]     ex_hi_write_data,
  input  logic [DATA_W-1:0]     ex_lo_write_data,
  input  logic                  ex_hilo_write_en,
  input  logic                  ex_cp0_reg_write_en,
  input  logic [4:0]            ex_cp0_reg_write_addr,
  input  logic [DATA_W-1:0]     ex_cp0_reg_write_data,
  input  logic                  ex_LLbit_write_en,
  input  logic                  ex_LLbit_data,
  input  logic                  flush,
  output logic [DATA_W-1:0]     mem_reg_write_data,
  output logic [REG_ADDR_W-1:0] mem_reg_write_addr,
  output logic                  mem_reg_write_en,
  output logic [DATA_W-1:0]     mem_hi_write_data,
  output logic [DATA_W-1:0]     mem_lo_write_data,
  output logic                  mem_hilo_write_en,
  output logic                  mem_cp0_reg_write_en,
  output logic [4:0]            mem_cp0_reg_write_addr,
  output logic [DATA_W-1:0]     mem_cp0_reg_write_data,
  output logic                  mem_LLbit_write_en,
  output logic                  mem_LLbit_data,
  output logic                  stallreq_mem,
  output logic                  data_req,
  output logic                  data_we,
  output logic [DATA_W-1:0]     data_addr,
  output logic [3:0]            data_sel,
  output logic [DATA_W-1:0]     data_wdata,
  input  logic [DATA_W-1:0]     data_rdata,
  input  logic                  data_ack,
  output logic                  excp_adel,
  output logic                  excp_ades,
  output logic [DATA_W-1:0]     excp_badvaddr
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ABORT} state_t;

  state_t            state_q;
  logic              req_q, we_q;
  logic [DATA_W-1:0] addr_q, wdata_q, rdata_q;
  logic [3:0]        sel_q, op_q;

  logic              is_load, is_store, is_byte, is_half, is_word;
  logic              misalign, idle_go;
  logic [DATA_W-1:0] addr_d, wdata_d;
  logic [3:0]        sel_d;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    case (mem_op)
      OP_LB, OP_LBU: begin is_load  = 1'b1; is_byte = 1'b1; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
      OP_LW:         begin is_load  = 1'b1; is_word = 1'b1; end
      OP_SB:         begin is_store = 1'b1; is_byte = 1'b1; end
      OP_SH:         begin is_store = 1'b1; is_half = 1'b1; end
      OP_SW:         begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
  end

`ifdef UNALIGNED_EXC_EN
  assign misalign      = (is_half && mem_addr[0]) || (is_word && (mem_addr[1:0] != 2'b00));
  assign addr_d        = mem_addr;
  assign excp_adel     = !rst && (state_q == S_IDLE) && is_load && misalign;
  assign excp_ades     = !rst && (state_q == S_IDLE) && is_store && misalign;
  assign excp_badvaddr = (excp_adel || excp_ades) ? mem_addr : '0;
`else
  assign misalign      = 1'b0;
  assign addr_d        = {mem_addr[DATA_W-1:2], mem_addr[1] & ~is_word, mem_addr[0] & ~(is_half | is_word)};
  assign excp_adel     = 1'b0;
  assign excp_ades     = 1'b0;
  assign excp_badvaddr = '0;
`endif

  always_comb begin
    sel_d   = 4'b0000;
    wdata_d = '0;
    if (is_byte) begin
      sel_d   = 4'b0001 << addr_d[1:0];
      wdata_d = {4{mem_store_data[7:0]}};
    end else if (is_half) begin
      sel_d   = addr_d[1] ? 4'b1100 : 4'b0011;
      wdata_d = {2{mem_store_data[15:0]}};
    end else if (is_word) begin
      sel_d   = 4'b1111;
      wdata_d = mem_store_data;
    end
    if (!is_store) wdata_d = '0;
  end

  assign idle_go      = (state_q == S_IDLE) && (is_load || is_store) && !misalign && !flush;
  assign stallreq_mem = !rst && (idle_go || (state_q == S_REQ) || (state_q == S_ABORT));

  // Once raised, the request is held until ack even if the op is flushed (ABORT).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= 4'b0000;
      wdata_q <= '0;
      rdata_q <= '0;
      op_q    <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (idle_go) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            we_q    <= is_store;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            op_q    <= mem_op;
          end
        end
        S_REQ: begin
          if (data_ack) begin
            state_q <= S_DONE;
            req_q   <= 1'b0;
            rdata_q <= data_rdata;
          end else if (flush) begin
            state_q <= S_ABORT;
          end
        end
        S_DONE: state_q <= S_IDLE;
        S_ABORT: begin
          if (data_ack) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_req   = req_q;
  assign data_we    = we_q;
  assign data_addr  = addr_q;
  assign data_sel   = sel_q;
  assign data_wdata = wdata_q;

  always_comb begin
    ld_byte = rdata_q[7:0];
    case (addr_q[1:0])
      2'd1:    ld_byte = rdata_q[15:8];
      2'd2:    ld_byte = rdata_q[23:16];
      2'd3:    ld_byte = rdata_q[31:24];
      default: ;
    endcase
    ld_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
  end

  always_comb begin
    mem_reg_write_data = ex_reg_write_data;
    if (state_q == S_DONE) begin
      case (op_q)
        OP_LB:   mem_reg_write_data = {{24{ld_byte[7]}}, ld_byte};
        OP_LBU:  mem_reg_write_data = {24'd0, ld_byte};
        OP_LH:   mem_reg_write_data = {{16{ld_half[15]}}, ld_half};
        OP_LHU:  mem_reg_write_data = {16'd0, ld_half};
        OP_LW:   mem_reg_write_data = rdata_q;
        default: ;
      endcase
    end
  end

  assign mem_reg_write_addr     = ex_reg_write_addr;
  assign mem_reg_write_en       = ex_reg_write_en && !rst && !flush && !stallreq_mem && !excp_adel && !excp_ades;
  assign mem_hi_write_data      = ex_hi_write_data;
  assign mem_lo_write_data      = ex_lo_write_data;
  assign mem_hilo_write_en      = ex_hilo_write_en && !rst && !flush;
  assign mem_cp0_reg_write_en   = ex_cp0_reg_write_en && !rst && !flush;
  assign mem_cp0_reg_write_addr = ex_cp0_reg_write_addr;
  assign mem_cp0_reg_write_data = ex_cp0_reg_write_data;
  assign mem_LLbit_write_en     = ex_LLbit_write_en && !rst && !flush;
  assign mem_LLbit_data         = ex_LLbit_data;

endmodule

// File: tb/tb_mem_dbus_stage.sv
// Bench for mem_dbus_stage: per-instruction timeline model with random ops, waits and flushes,
// a single negedge compare process, and literal checks on the directed scenarios.
module tb_mem_dbus_stage;

  logic        clk, rst, flush, data_ack;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr, mem_store_data, data_rdata;
  logic [31:0] ex_reg_write_data, ex_hi_write_data, ex_lo_write_data, ex_cp0_reg_write_data;
  logic [4:0]  ex_reg_write_addr, ex_cp0_reg_write_addr;
  logic        ex_reg_write_en, ex_hilo_write_en, ex_cp0_reg_write_en, ex_LLbit_write_en, ex_LLbit_data;
  logic [31:0] mem_reg_write_data, mem_hi_write_data, mem_lo_write_data, mem_cp0_reg_write_data;
  logic [4:0]  mem_reg_write_addr, mem_cp0_reg_write_addr;
  logic        mem_reg_write_en, mem_hilo_write_en, mem_cp0_reg_write_en, mem_LLbit_write_en, mem_LLbit_data;
  logic        stallreq_mem, data_req, data_we, excp_adel, excp_ades;
  logic [31:0] data_addr, data_wdata, excp_badvaddr;
  logic [3:0]  data_sel;

  mem_dbus_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .mem_op(mem_op), .mem_addr(mem_addr), .mem_store_data(mem_store_data),
    .ex_reg_write_data(ex_reg_write_data), .ex_reg_write_addr(ex_reg_write_addr), .ex_reg_write_en(ex_reg_write_en),
    .ex_hi_write_data(ex_hi_write_data), .ex_lo_write_data(ex_lo_write_data), .ex_hilo_write_en(ex_hilo_write_en),
    .ex_cp0_reg_write_en(ex_cp0_reg_write_en), .ex_cp0_reg_write_addr(ex_cp0_reg_write_addr),
    .ex_cp0_reg_write_data(ex_cp0_reg_write_data), .ex_LLbit_write_en(ex_LLbit_write_en), .ex_LLbit_data(ex_LLbit_data),
    .flush(flush), .mem_reg_write_data(mem_reg_write_data), .mem_reg_write_addr(mem_reg_write_addr),
    .mem_reg_write_en(mem_reg_write_en), .mem_hi_write_data(mem_hi_write_data), .mem_lo_write_data(mem_lo_write_data),
    .mem_hilo_write_en(mem_hilo_write_en), .mem_cp0_reg_write_en(mem_cp0_reg_write_en),
    .mem_cp0_reg_write_addr(mem_cp0_reg_write_addr), .mem_cp0_reg_write_data(mem_cp0_reg_write_data),
    .mem_LLbit_write_en(mem_LLbit_write_en), .mem_LLbit_data(mem_LLbit_data), .stallreq_mem(stallreq_mem),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_sel(data_sel), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_ack(data_ack), .excp_adel(excp_adel), .excp_ades(excp_ades),
    .excp_badvaddr(excp_badvaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Staged instruction fields, applied just after a rising edge.
  logic [3:0]  nx_op;
  logic [31:0] nx_addr, nx_sd, nx_reg_data, nx_hi, nx_lo, nx_cp0_data;
  logic [4:0]  nx_reg_addr, nx_cp0_addr;
  logic        nx_reg_en, nx_hilo_en, nx_cp0_en, nx_ll_en, nx_ll_data;

  // Expected outputs for the current cycle.
  logic        exp_on, exp_stall, exp_req, exp_reg_en, exp_hilo_en, exp_cp0_en, exp_ll_en;
  logic        exp_adel, exp_ades, exp_bus_chk, exp_bus_zero, exp_is_store, exp_we;
  logic [31:0] exp_reg_data, exp_bad, exp_addr, exp_wdata;
  logic [3:0]  exp_sel;

  // Observations for the literal checks.
  int          obs_stalls, obs_req_cycles;
  logic        obs_en_any, obs_reg_en, obs_adel, obs_we;
  logic [31:0] obs_res, obs_bad, obs_wdata, obs_addr;
  logic [3:0]  obs_sel;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic int unsigned opsize(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd2 || op == 4'd6) return 1;
    if (op == 4'd3 || op == 4'd4 || op == 4'd7) return 2;
    if (op == 4'd5 || op == 4'd8) return 4;
    return 0;
  endfunction

  function automatic bit misal(input logic [3:0] op, input logic [31:0] a);
`ifdef UNALIGNED_EXC_EN
    return opsize(op) != 0 && (a % opsize(op)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] bus_addr(input logic [3:0] op, input logic [31:0] a);
    int unsigned sz = opsize(op);
`ifdef UNALIGNED_EXC_EN
    return a;
`else
    return (sz == 0) ? a : a - (a % sz);
`endif
  endfunction

  function automatic logic [3:0] sel_of(input logic [3:0] op, input logic [31:0] a);
    int unsigned sz = opsize(op);
    logic [7:0] t;
    t = ((8'd1 << sz) - 8'd1) << (bus_addr(op, a) % 4);
    return t[3:0];
  endfunction

  function automatic logic [31:0] wdata_of(input logic [3:0] op, input logic [31:0] sd);
    int unsigned sz = opsize(op);
    logic [63:0] v, mask;
    if (sz == 0) return 32'd0;
    v = 64'd0;
    mask = (64'd1 << (8 * sz)) - 64'd1;
    for (int i = 0; i < 4; i += sz) v |= ({32'd0, sd} & mask) << (8 * i);
    return v[31:0];
  endfunction

  function automatic logic [31:0] load_of(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd);
    int unsigned sz = opsize(op);
    logic [63:0] v, mask;
    mask = (64'd1 << (8 * sz)) - 64'd1;
    v = ({32'd0, rd} >> (8 * (bus_addr(op, a) % 4))) & mask;
    if ((op == 4'd1 || op == 4'd3) && v[8 * sz - 1]) v |= ~mask;
    return v[31:0];
  endfunction

  task automatic rand_pt();
    nx_reg_data = $urandom; nx_reg_addr = 5'($urandom); nx_reg_en = 1'($urandom);
    nx_hi = $urandom; nx_lo = $urandom; nx_hilo_en = 1'($urandom);
    nx_cp0_en = 1'($urandom); nx_cp0_addr = 5'($urandom); nx_cp0_data = $urandom;
    nx_ll_en = 1'($urandom); nx_ll_data = 1'($urandom);
  endtask

  task automatic clear_obs();
    obs_stalls = 0; obs_req_cycles = 0; obs_en_any = 1'b0; obs_adel = 1'b0;
    obs_res = 32'd0; obs_bad = 32'd0; obs_reg_en = 1'b0;
  endtask

  task automatic drive_cycle(input bit rs, input bit st, input bit rq, input bit fl, input bit ack,
                             input logic [31:0] rd, input logic [31:0] regdata, input bit exl, input bit exs);
    @(posedge clk);
    #1;
    rst = rs; flush = fl; data_ack = ack; data_rdata = rd;
    mem_op = nx_op; mem_addr = nx_addr; mem_store_data = nx_sd;
    ex_reg_write_data = nx_reg_data; ex_reg_write_addr = nx_reg_addr; ex_reg_write_en = nx_reg_en;
    ex_hi_write_data = nx_hi; ex_lo_write_data = nx_lo; ex_hilo_write_en = nx_hilo_en;
    ex_cp0_reg_write_en = nx_cp0_en; ex_cp0_reg_write_addr = nx_cp0_addr; ex_cp0_reg_write_data = nx_cp0_data;
    ex_LLbit_write_en = nx_ll_en; ex_LLbit_data = nx_ll_data;
    exp_stall = st; exp_req = rq; exp_bus_chk = rq; exp_reg_data = regdata;
    exp_reg_en  = nx_reg_en && !rs && !fl && !st && !exl && !exs;
    exp_hilo_en = nx_hilo_en && !rs && !fl;
    exp_cp0_en  = nx_cp0_en && !rs && !fl;
    exp_ll_en   = nx_ll_en && !rs && !fl;
    exp_adel = exl; exp_ades = exs; exp_bad = nx_addr;
    exp_on = 1'b1;
    @(negedge clk);
    if (stallreq_mem) obs_stalls++;
    if (data_req) begin
      obs_req_cycles++;
      obs_sel = data_sel; obs_wdata = data_wdata; obs_we = data_we; obs_addr = data_addr;
    end
    obs_en_any |= mem_reg_write_en;
    obs_reg_en = mem_reg_write_en;
    obs_res = mem_reg_write_data;
    if (excp_adel) begin obs_adel = 1'b1; obs_bad = excp_badvaddr; end
  endtask

  // One instruction: IDLE cycle, wait_n+1 REQ cycles (ack on the last), then DONE.
  // flush_at in 1..wait_n flushes that REQ cycle and the access finishes in ABORT.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rd,
                        input int wait_n, input int flush_at, input bit flush_done, input bit flush_idle);
    bit memop, exc, ld;
    logic [31:0] res;
    nx_op = op; nx_addr = addr; nx_sd = sd;
    memop = opsize(op) != 0;
    exc = misal(op, addr);
    ld = memop && op <= 4'd5;
    if (exc) flush_idle = 1'b0;
    exp_we = memop && !ld; exp_is_store = memop && !ld;
    exp_addr = bus_addr(op, addr); exp_sel = sel_of(op, addr); exp_wdata = wdata_of(op, sd);
    res = ld ? load_of(op, addr, rd) : nx_reg_data;
    clear_obs();
    if (!memop || exc || flush_idle) begin
      drive_cycle(0, 0, 0, flush_idle, 0, $urandom, nx_reg_data, exc && ld, exc && !ld);
    end else begin
      drive_cycle(0, 1, 0, 0, 0, $urandom, nx_reg_data, 0, 0);
      for (int k = 1; k <= wait_n + 1; k++)
        drive_cycle(0, 1, 1, k == flush_at, k == wait_n + 1, (k == wait_n + 1) ? rd : $urandom, nx_reg_data, 0, 0);
      if (flush_at <= 0) drive_cycle(0, 0, 0, flush_done, 0, $urandom, res, 0, 0);
    end
  endtask

  initial begin
    exp_on = 1'b0;
    forever begin
      @(negedge clk);
      if (exp_on) begin
        chk("stallreq_mem", stallreq_mem, exp_stall);
        chk("data_req", data_req, exp_req);
        chk("reg_write_data", mem_reg_write_data, exp_reg_data);
        chk("reg_write_addr", mem_reg_write_addr, nx_reg_addr);
        chk("reg_write_en", mem_reg_write_en, exp_reg_en);
        chk("hi_data", mem_hi_write_data, nx_hi);
        chk("lo_data", mem_lo_write_data, nx_lo);
        chk("hilo_en", mem_hilo_write_en, exp_hilo_en);
        chk("cp0_en", mem_cp0_reg_write_en, exp_cp0_en);
        chk("cp0_addr", mem_cp0_reg_write_addr, nx_cp0_addr);
        chk("cp0_data", mem_cp0_reg_write_data, nx_cp0_data);
        chk("llbit_en", mem_LLbit_write_en, exp_ll_en);
        chk("llbit_data", mem_LLbit_data, nx_ll_data);
        chk("excp_adel", excp_adel, exp_adel);
        chk("excp_ades", excp_ades, exp_ades);
`ifdef UNALIGNED_EXC_EN
        if (exp_adel || exp_ades) chk("excp_badvaddr", excp_badvaddr, exp_bad);
`else
        chk("excp_badvaddr", excp_badvaddr, 32'd0);
`endif
        if (exp_bus_chk) begin
          chk("data_we", data_we, exp_we);
          chk("data_addr", data_addr, exp_addr);
          chk("data_sel", data_sel, exp_sel);
          if (exp_is_store) chk("data_wdata", data_wdata, exp_wdata);
        end
        if (exp_bus_zero) begin
          chk("rst_data_we", data_we, 32'd0);
          chk("rst_data_addr", data_addr, 32'd0);
          chk("rst_data_sel", data_sel, 32'd0);
          chk("rst_data_wdata", data_wdata, 32'd0);
        end
      end
    end
  end

  initial begin
    logic [3:0] op;
    logic [31:0] addr;
    int w, fa;
    rst = 1'b1; flush = 1'b0; data_ack = 1'b0; data_rdata = 32'd0;
    mem_op = 4'd0; mem_addr = 32'd0; mem_store_data = 32'd0;
    ex_reg_write_data = 32'd0; ex_reg_write_addr = 5'd0; ex_reg_write_en = 1'b0;
    ex_hi_write_data = 32'd0; ex_lo_write_data = 32'd0; ex_hilo_write_en = 1'b0;
    ex_cp0_reg_write_en = 1'b0; ex_cp0_reg_write_addr = 5'd0; ex_cp0_reg_write_data = 32'd0;
    ex_LLbit_write_en = 1'b0; ex_LLbit_data = 1'b0;
    exp_bus_zero = 1'b0; exp_bus_chk = 1'b0; exp_is_store = 1'b0;

    // Reset: enables forced low, bus registers zero.
    rand_pt();
    nx_op = 4'd5; nx_addr = 32'h100; nx_sd = 32'd0;
    nx_reg_en = 1'b1; nx_hilo_en = 1'b1; nx_cp0_en = 1'b1; nx_ll_en = 1'b1;
    exp_bus_zero = 1'b1;
    drive_cycle(1, 0, 0, 0, 0, 32'd0, nx_reg_data, 0, 0);
    drive_cycle(1, 0, 0, 0, 0, 32'd0, nx_reg_data, 0, 0);
    nx_op = 4'd0;
    drive_cycle(0, 0, 0, 0, 0, 32'd0, nx_reg_data, 0, 0);
    exp_bus_zero = 1'b0;

    // LW 0x100, ack in first REQ cycle.
    rand_pt(); nx_reg_en = 1'b1;
    run_op(4'd5, 32'h100, 32'd0, 32'hDEADBEEF, 0, 0, 0, 0);
    chk("lit_lw_stalls", obs_stalls, 2);
    chk("lit_lw_data", obs_res, 32'hDEADBEEF);
    chk("lit_lw_en", obs_reg_en, 1);

    // LB / LBU at 0x103.
    rand_pt(); nx_reg_en = 1'b1;
    run_op(4'd1, 32'h103, 32'd0, 32'h80123456, 0, 0, 0, 0);
    chk("lit_lb_sel", obs_sel, 4'b1000);
    chk("lit_lb_data", obs_res, 32'hFFFFFF80);
    rand_pt(); nx_reg_en = 1'b1;
    run_op(4'd2, 32'h103, 32'd0, 32'h80123456, 0, 0, 0, 0);
    chk("lit_lbu_data", obs_res, 32'h00000080);

    // SH 0x102 with three wait cycles.
    rand_pt(); nx_reg_en = 1'b0;
    run_op(4'd7, 32'h102, 32'h0000ABCD, 32'd0, 3, 0, 0, 0);
    chk("lit_sh_sel", obs_sel, 4'b1100);
    chk("lit_sh_wdata", obs_wdata, 32'hABCDABCD);
    chk("lit_sh_we", obs_we, 1);
    chk("lit_sh_stalls", obs_stalls, 5);

    // Flush in the first REQ cycle, ack two cycles later.
    rand_pt(); nx_reg_en = 1'b1;
    run_op(4'd5, 32'h140, 32'd0, 32'h12345678, 2, 1, 0, 0);
    chk("lit_flush_req_cycles", obs_req_cycles, 3);
    chk("lit_flush_no_wb", obs_en_any, 0);
    chk("lit_flush_stalls", obs_stalls, 4);

    // Misaligned LW at 0x102.
    rand_pt(); nx_reg_en = 1'b1;
    run_op(4'd5, 32'h102, 32'd0, 32'hCAFEF00D, 0, 0, 0, 0);
`ifdef UNALIGNED_EXC_EN
    chk("lit_adel", obs_adel, 1);
    chk("lit_badvaddr", obs_bad, 32'h102);
    chk("lit_adel_no_req", obs_req_cycles, 0);
`else
    chk("lit_aligned_addr", obs_addr, 32'h100);
    chk("lit_aligned_data", obs_res, 32'hCAFEF00D);
`endif

    // ADDU r3 = 5 passes straight through.
    rand_pt(); nx_reg_data = 32'h5; nx_reg_addr = 5'd3; nx_reg_en = 1'b1;
    run_op(4'd0, 32'h0, 32'd0, 32'd0, 0, 0, 0, 0);
    chk("lit_addu_stalls", obs_stalls, 0);
    chk("lit_addu_data", obs_res, 32'h5);
    chk("lit_addu_en", obs_reg_en, 1);

    // Randomized instruction stream.
    for (int i = 0; i < 400; i++) begin
      rand_pt();
      op   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
      addr = 32'h100 + $urandom_range(0, 255);
      w    = int'($urandom_range(0, 3));
      fa   = (w > 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, w)) : 0;
      run_op(op, addr, $urandom, $urandom, w, fa, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
    end

    // Reset while a request is outstanding.
    rand_pt();
    nx_op = 4'd5; nx_addr = 32'h200; nx_sd = 32'd0;
    exp_we = 1'b0; exp_is_store = 1'b0; exp_addr = 32'h200; exp_sel = 4'b1111;
    drive_cycle(0, 1, 0, 0, 0, 32'd0, nx_reg_data, 0, 0);
    drive_cycle(0, 1, 1, 0, 0, 32'd0, nx_reg_data, 0, 0);
    drive_cycle(1, 0, 1, 0, 0, 32'd0, nx_reg_data, 0, 0);
    nx_op = 4'd0;
    clear_obs();
    exp_bus_zero = 1'b1;
    drive_cycle(0, 0, 0, 0, 0, 32'd0, nx_reg_data, 0, 0);
    exp_bus_zero = 1'b0;
    chk("lit_rst_midreq_req", obs_req_cycles, 0);
    chk("lit_rst_midreq_stall", obs_stalls, 0);

    @(posedge clk);
    #1;
    exp_on = 1'b0;
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
